// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - Fetch stage and IF/ID register (optional perf counters: IF_ID_PERF_CNT_EN)
module if_id_stage #(
   parameter int                DATA_W   = 16,
   parameter int                PC_INC   = 2,
   parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   input  logic [DATA_W-1:0] imem_instr,
   input  logic              hlt_retired,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] if_id_instr,
   output logic [DATA_W-1:0] if_id_pc_plus2,
   output logic              if_id_valid,
   output logic [3:0]        if_id_opcode,
   output logic [3:0]        if_id_rs,
   output logic [3:0]        if_id_rt,
   output logic              if_id_branch,
   output logic              if_id_MemWrite,
   output logic              halted,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] pc_seq;
   logic              fetch_is_hlt;

   assign pc_seq       = pc + DATA_W'(PC_INC);
   assign fetch_is_hlt = (imem_instr[DATA_W-1 -: 4] == 4'hF);

   // PC, IF/ID register and halt sequencing; stall outranks everything but reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc             <= RESET_PC;
         if_id_instr    <= '0;
         if_id_pc_plus2 <= '0;
         if_id_valid    <= 1'b0;
         state          <= ST_RUN;
         halted         <= 1'b0;
      end else if (state != ST_HALTED && !stall) begin
         if (state == ST_DRAIN) begin
            // HLT is already latched; feed bubbles until it retires
            if_id_instr    <= '0;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
            if (hlt_retired) begin
               state  <= ST_HALTED;
               halted <= 1'b1;
            end
         end else if (branch_taken) begin
            // squash the wrong-path word fetched this cycle
            pc             <= branch_target;
            if_id_instr    <= '0;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
         end else begin
            if_id_instr    <= imem_instr;
            if_id_pc_plus2 <= pc_seq;
            if_id_valid    <= 1'b1;
            if (fetch_is_hlt) begin
               state <= ST_DRAIN;
            end else begin
               pc <= pc_seq;
            end
         end
      end
   end

   // field pre-decode for the hazard unit; everything reads zero for a bubble
   always_comb begin
      if_id_opcode   = 4'h0;
      if_id_rs       = 4'h0;
      if_id_rt       = 4'h0;
      if_id_branch   = 1'b0;
      if_id_MemWrite = 1'b0;
      if (if_id_valid) begin
         if_id_opcode   = if_id_instr[15:12];
         if_id_rs       = (if_id_instr[15:12] == 4'hA || if_id_instr[15:12] == 4'hB)
                          ? if_id_instr[11:8] : if_id_instr[7:4];
         if_id_rt       = (if_id_instr[15:12] == 4'h9) ? if_id_instr[11:8] : if_id_instr[3:0];
         if_id_branch   = (if_id_instr[15:12] == 4'hC || if_id_instr[15:12] == 4'hD);
         if_id_MemWrite = (if_id_instr[15:12] == 4'h9);
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   // saturating stall and branch-squash counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'h0000;
         flush_cnt <= 16'h0000;
      end else begin
         if (stall && state != ST_HALTED && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'h0001;
         end
         if (!stall && branch_taken && state == ST_RUN && flush_cnt != 16'hFFFF) begin
            flush_cnt <= flush_cnt + 16'h0001;
         end
      end
   end
`else
   assign stall_cnt = 16'h0000;
   assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - Self-checking bench for if_id_stage
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] imem_instr;
   logic        hlt_retired;
   logic [15:0] pc;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_plus2;
   logic        if_id_valid;
   logic [3:0]  if_id_opcode;
   logic [3:0]  if_id_rs;
   logic [3:0]  if_id_rt;
   logic        if_id_branch;
   logic        if_id_MemWrite;
   logic        halted;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int checks = 0;
   int errors = 0;

`ifdef IF_ID_PERF_CNT_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   if_id_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_instr(imem_instr), .hlt_retired(hlt_retired),
      .pc(pc), .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
      .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs),
      .if_id_rt(if_id_rt), .if_id_branch(if_id_branch), .if_id_MemWrite(if_id_MemWrite),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // program image: same-cycle read at pc
   function automatic logic [15:0] imem_f(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h0123;
         16'h0002: return 16'h8456;
         16'h0004: return 16'hD0E0;
         16'h0006: return 16'hF000;
         16'h0040: return 16'h9712;
         16'h0042: return 16'hA512;
         16'h0044: return 16'hB3C4;
         16'h0046: return 16'hC001;
         16'hFFFE: return 16'h2345;
         default:  return 16'h1111;
      endcase
   endfunction

   always_comb imem_instr = imem_f(pc);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: integer PC, flags for draining/halted
   int m_pc, m_pp2, m_instr, m_stalls, m_flushes;
   bit m_valid, m_draining, m_halted;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 0; m_instr = 0; m_pp2 = 0; m_valid = 0;
         m_draining = 0; m_halted = 0; m_stalls = 0; m_flushes = 0;
      end else if (!m_halted) begin
         if (stall) begin
            m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
         end else if (m_draining) begin
            m_valid = 0; m_instr = 0;
            if (hlt_retired) begin
               m_halted = 1; m_draining = 0;
            end
         end else if (branch_taken) begin
            m_pc = branch_target; m_valid = 0; m_instr = 0;
            m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
         end else begin
            m_instr = imem_f(16'(m_pc));
            m_valid = 1;
            m_pp2   = (m_pc + 2) % 65536;
            if ((m_instr / 4096) == 15) m_draining = 1;
            else m_pc = m_pp2;
         end
      end
   end

   function automatic int e_op();
      return m_valid ? (m_instr / 4096) : 0;
   endfunction
   function automatic int e_rs();
      if (!m_valid) return 0;
      return (e_op() == 10 || e_op() == 11) ? (m_instr / 256) % 16 : (m_instr / 16) % 16;
   endfunction
   function automatic int e_rt();
      if (!m_valid) return 0;
      return (e_op() == 9) ? (m_instr / 256) % 16 : m_instr % 16;
   endfunction

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("m_pc", pc, m_pc);
         chk("m_valid", if_id_valid, m_valid);
         chk("m_instr", if_id_instr, m_valid ? m_instr : 0);
         if (m_valid) chk("m_pc_plus2", if_id_pc_plus2, m_pp2);
         chk("m_opcode", if_id_opcode, e_op());
         chk("m_rs", if_id_rs, e_rs());
         chk("m_rt", if_id_rt, e_rt());
         chk("m_branch", if_id_branch, (e_op() == 12 || e_op() == 13));
         chk("m_memwrite", if_id_MemWrite, (e_op() == 9));
         chk("m_halted", halted, m_halted);
         chk("m_stall_cnt", stall_cnt, PERF ? m_stalls : 0);
         chk("m_flush_cnt", flush_cnt, PERF ? m_flushes : 0);
      end
   end

   task automatic cyc(input logic s, input logic b, input logic [15:0] t, input logic h);
      stall = s; branch_taken = b; branch_target = t; hlt_retired = h;
      @(posedge clk); #1;
      stall = 0; branch_taken = 0; branch_target = 0; hlt_retired = 0;
   endtask

   initial begin
      rst = 1; stall = 0; branch_taken = 0; branch_target = 0; hlt_retired = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_valid", if_id_valid, 0);
      chk("rst_instr", if_id_instr, 16'h0000);
      chk("rst_halted", halted, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      rst = 0;

      cyc(0, 0, 0, 0);
      chk("t1_instr", if_id_instr, 16'h0123);
      chk("t1_pp2", if_id_pc_plus2, 16'h0002);
      chk("t1_rs", if_id_rs, 2);
      chk("t1_rt", if_id_rt, 3);
      chk("t1_pc", pc, 16'h0002);

      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("t2_pc_a", pc, 16'h0004);
      chk("t2_instr_a", if_id_instr, 16'h8456);
      cyc(1, 0, 0, 0);
      chk("t2_pc_b", pc, 16'h0004);
      chk("t2_instr_b", if_id_instr, 16'h8456);
      chk("t2_stall_cnt", stall_cnt, PERF ? 2 : 0);

      cyc(0, 0, 0, 1);
      chk("run_hltret_ign", halted, 0);
      chk("br_decode", if_id_branch, 1);
      chk("br_pc", pc, 16'h0006);

      cyc(1, 1, 16'h0040, 0);
      chk("t4_pc", pc, 16'h0006);
      chk("t4_instr", if_id_instr, 16'hD0E0);
      chk("t4_flush_cnt", flush_cnt, 0);

      cyc(0, 1, 16'h0040, 0);
      chk("t3_pc", pc, 16'h0040);
      chk("t3_valid", if_id_valid, 0);
      chk("t3_instr", if_id_instr, 16'h0000);
      chk("t3_flush_cnt", flush_cnt, PERF ? 1 : 0);

      cyc(0, 0, 0, 0);
      chk("t3_fetch40", if_id_instr, 16'h9712);
      chk("sw_rt", if_id_rt, 7);
      chk("sw_memwrite", if_id_MemWrite, 1);
      cyc(0, 0, 0, 0);
      chk("llb_rs", if_id_rs, 5);
      cyc(0, 0, 0, 0);
      chk("lhb_rs", if_id_rs, 3);
      cyc(0, 0, 0, 0);
      chk("b_branch", if_id_branch, 1);

      cyc(0, 1, 16'hFFFE, 0);
      chk("wrap_pre_pc", pc, 16'hFFFE);
      cyc(0, 0, 0, 0);
      chk("wrap_pc", pc, 16'h0000);
      chk("wrap_pp2", if_id_pc_plus2, 16'h0000);
      chk("wrap_instr", if_id_instr, 16'h2345);

      repeat (3) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t5_pc_hold", pc, 16'h0006);
      chk("t5_hlt_latched", if_id_instr, 16'hF000);
      chk("t5_hlt_op", if_id_opcode, 4'hF);
      cyc(0, 1, 16'h0040, 0);
      chk("t5_drain_pc", pc, 16'h0006);
      chk("t5_drain_bubble", if_id_valid, 0);
      chk("t5_drain_flush", flush_cnt, PERF ? 2 : 0);
      cyc(0, 0, 0, 1);
      chk("t5_halted", halted, 1);
      cyc(1, 1, 16'h0080, 0);
      cyc(0, 1, 16'h0080, 0);
      chk("t5_halt_pc", pc, 16'h0006);
      chk("t5_halt_stay", halted, 1);
      chk("t5_halt_stall_cnt", stall_cnt, PERF ? 3 : 0);

      rst = 1;
      #1;
      chk("async_rst_pc", pc, 16'h0000);
      chk("async_rst_halted", halted, 0);
      @(posedge clk); #2;
      rst = 0;
      chk("async_rst_cnt", stall_cnt, 0);

      repeat (4) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("drain_pc", pc, 16'h0006);
      #2 rst = 1;
      #2 rst = 0;
      chk("drain_rst_pc", pc, 16'h0000);
      cyc(0, 0, 0, 0);
      chk("drain_rst_run", if_id_instr, 16'h0123);
      chk("drain_rst_pc2", pc, 16'h0002);

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
